// File: rtl/smoldvi_deserialiser.sv
// One-lane TMDS deserialiser: rebuilds 10-bit symbols from a 2-bit/clk DDR stream and aligns on control-symbol runs.
// Optional statistics outputs (slip_count, lock_loss) are built when SMOLDVI_DESER_STATS_EN is defined.
module smoldvi_deserialiser #(
  parameter int LOCK_COUNT   = 8,
  parameter int SEARCH_WORDS = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din,
  input  logic       resync,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       dout_ctrl,
  output logic       locked
`ifdef SMOLDVI_DESER_STATS_EN
  ,
  output logic [7:0] slip_count,
  output logic       lock_loss
`endif
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W = $clog2(SEARCH_WORDS + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic is_ctrl(input logic [9:0] s);
    return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] c);
    return (c == RUN_W'(LOCK_COUNT)) ? c : c + 1'b1;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_slip;
  logic [3:0]       w_slip_nxt;
  logic [2:0]       r_phase;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nxt;
  logic [RUN_W-1:0] w_run_cand;
  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] w_win_nxt;
  logic [WIN_W-1:0] w_win_inc;
  logic             r_discard;
  logic             w_discard_nxt;

  // Capture stage: only the newest 11 bits are ever needed, since a window
  // is taken the clock after its final bit arrives for either bit offset.
  logic [10:0]      r_sr_p0;
  logic [9:0]       w_word_p0;
  logic             w_strobe_p0;
  logic             w_ctrl_p0;

  // Output stage
  logic [9:0]       r_dout_p1;
  logic             r_ctrl_p1;
  logic             r_vld_p1;

  assign w_word_p0   = r_sr_p0[r_slip[0] +: 10];
  assign w_strobe_p0 = (r_phase == r_slip[3:1]);
  assign w_ctrl_p0   = is_ctrl(w_word_p0);
  assign w_run_cand  = w_ctrl_p0 ? sat_inc_run(r_run) : '0;
  assign w_win_inc   = r_win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr_p0 <= '0;
      r_phase <= '0;
    end else begin
      r_sr_p0 <= {din, r_sr_p0[10:2]};
      r_phase <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_run_nxt     = r_run;
    w_win_nxt     = r_win;
    w_slip_nxt    = r_slip;
    w_discard_nxt = r_discard;
    case (r_state)
      HUNT, LOCKED: begin
        if (w_strobe_p0) begin
          if (r_discard) begin
            // Window straddles the old and new slip; let it pass uncounted.
            w_discard_nxt = 1'b0;
          end else if (w_run_cand == RUN_W'(LOCK_COUNT)) begin
            w_run_nxt   = w_run_cand;
            w_win_nxt   = '0;
            w_state_nxt = LOCKED;
          end else if (w_win_inc == WIN_W'(SEARCH_WORDS)) begin
            w_run_nxt   = '0;
            w_win_nxt   = '0;
            w_state_nxt = (r_state == LOCKED) ? HUNT : SLIP;
          end else begin
            w_run_nxt = w_run_cand;
            w_win_nxt = w_win_inc;
          end
        end
      end
      SLIP: begin
        w_slip_nxt    = (r_slip == 4'd9) ? 4'd0 : r_slip + 4'd1;
        w_run_nxt     = '0;
        w_win_nxt     = '0;
        w_discard_nxt = 1'b1;
        w_state_nxt   = HUNT;
      end
      default: begin
        w_state_nxt = HUNT;
      end
    endcase
    if (resync) begin
      w_state_nxt   = HUNT;
      w_run_nxt     = '0;
      w_win_nxt     = '0;
      w_slip_nxt    = r_slip;
      w_discard_nxt = r_discard;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HUNT;
      r_slip    <= '0;
      r_run     <= '0;
      r_win     <= '0;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_slip    <= w_slip_nxt;
      r_run     <= w_run_nxt;
      r_win     <= w_win_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_p1 <= '0;
      r_ctrl_p1 <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      if (w_strobe_p0) begin
        r_dout_p1 <= w_word_p0;
        r_ctrl_p1 <= w_ctrl_p0;
      end
      r_vld_p1 <= w_strobe_p0 && (r_state == LOCKED);
    end
  end

  assign dout       = r_dout_p1;
  assign dout_ctrl  = r_ctrl_p1;
  assign dout_valid = r_vld_p1;
  assign locked     = (r_state == LOCKED);

`ifdef SMOLDVI_DESER_STATS_EN
  logic [7:0] r_slip_count;
  logic       r_lock_loss;
  logic       w_lock_lost;

  // In LOCKED the only ways back to HUNT are timeout and resync.
  assign w_lock_lost = (r_state == LOCKED) && (w_state_nxt == HUNT) && !resync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slip_count <= '0;
      r_lock_loss  <= 1'b0;
    end else begin
      if ((r_state == SLIP) && !resync && (r_slip_count != 8'hFF))
        r_slip_count <= r_slip_count + 8'd1;
      r_lock_loss <= w_lock_lost;
    end
  end

  assign slip_count = r_slip_count;
  assign lock_loss  = r_lock_loss;
`endif

endmodule
